// File: rtl/load_align_extend.sv
// load_align_extend
//   Pipelined load-data alignment/extension stage between the data-memory read
//   port and the register-file write-back mux. Picks the byte/half/word/dword
//   lane addressed by the low address bits, zero- or sign-extends it to DATA_W,
//   and flags misaligned or illegal-size accesses (data forced to 0).
//   A main output register plus one skid register give two entries, so
//   in_ready is registered and out_ready never reaches in_ready combinationally.
//
// Ports
//   clk, rst        rising-edge clock, synchronous active-high reset
//   flush           synchronous flush, drops every held entry
//   in_valid/ready  input handshake (in_ready registered)
//   in_data         raw aligned memory word
//   in_offset       low byte-address bits of the load
//   in_size         0 byte, 1 half, 2 word, 3 dword (illegal when DATA_W=32)
//   in_signed       1 sign-extend, 0 zero-extend
//   in_tag          side-band tag carried through unchanged
//   out_valid/ready output handshake
//   out_data        extended result
//   out_tag         tag of the result
//   out_misalign    address-error flag for this result
module load_align_extend #(
  parameter  int unsigned DATA_W = 32,
  parameter  int unsigned TAG_W  = 5,
  localparam int unsigned OFF_W  = $clog2(DATA_W / 8)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [OFF_W-1:0]  in_offset,
  input  logic [1:0]        in_size,
  input  logic              in_signed,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [TAG_W-1:0]  out_tag,
  output logic              out_misalign
);

  // ---------------- alignment / extension ----------------
  logic [OFF_W-1:0]  align_mask;
  logic [OFF_W-1:0]  eff_off;
  logic [DATA_W-1:0] shifted;
  logic [DATA_W-1:0] keep_mask;
  logic [DATA_W-1:0] ext_data;
  logic [DATA_W-1:0] res_data;
  logic              sign_bit;
  logic              res_mis;

  always_comb begin
    align_mask = '1;
    keep_mask  = '0;
    res_mis    = 1'b0;
    case (in_size)
      2'd0: begin
        keep_mask[7:0] = '1;
      end
      2'd1: begin
        align_mask[0]   = 1'b0;
        keep_mask[15:0] = '1;
        res_mis         = in_offset[0];
      end
      2'd2: begin
        align_mask[1:0] = '0;
        keep_mask[31:0] = '1;
        res_mis         = |in_offset[1:0];
      end
      default: begin
        align_mask = '0;
        keep_mask  = '1;
        res_mis    = (DATA_W == 32) || (|in_offset);
      end
    endcase

    // Offset bits below the access size are ignored for lane selection.
    eff_off = in_offset & align_mask;
    shifted = in_data >> {eff_off, 3'b000};

    case (in_size)
      2'd0:    sign_bit = shifted[7];
      2'd1:    sign_bit = shifted[15];
      2'd2:    sign_bit = shifted[31];
      default: sign_bit = 1'b0;
    endcase

    // A 32-bit word on a 32-bit datapath has an all-ones keep mask, so the
    // fill term vanishes and the word passes through unchanged.
    ext_data = (shifted & keep_mask) | ({DATA_W{sign_bit & in_signed}} & ~keep_mask);
    res_data = res_mis ? '0 : ext_data;
  end

  // ---------------- two-entry skid buffer ----------------
  logic              main_valid;
  logic              skid_valid;
  logic              ready_q;
  logic [DATA_W-1:0] main_data;
  logic [DATA_W-1:0] skid_data;
  logic [TAG_W-1:0]  main_tag;
  logic [TAG_W-1:0]  skid_tag;
  logic              main_mis;
  logic              skid_mis;

  logic accept;
  logic out_xfer;
  logic main_load_new;
  logic main_load_skid;
  logic skid_load_new;
  logic main_valid_d;
  logic skid_valid_d;

  assign accept   = in_valid && ready_q;
  assign out_xfer = main_valid && out_ready;

  always_comb begin
    main_load_new  = 1'b0;
    main_load_skid = 1'b0;
    skid_load_new  = 1'b0;
    main_valid_d   = main_valid;
    skid_valid_d   = skid_valid;
    if (accept) begin
      if (!main_valid || out_xfer) begin
        main_valid_d = 1'b1;
        if (skid_valid) begin
          main_load_skid = 1'b1;
          skid_load_new  = 1'b1;
        end else begin
          main_load_new = 1'b1;
        end
      end else begin
        skid_load_new = 1'b1;
        skid_valid_d  = 1'b1;
      end
    end else if (out_xfer) begin
      if (skid_valid) begin
        main_load_skid = 1'b1;
        skid_valid_d   = 1'b0;
      end else begin
        main_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      ready_q    <= 1'b1;
      main_data  <= '0;
      skid_data  <= '0;
      main_tag   <= '0;
      skid_tag   <= '0;
      main_mis   <= 1'b0;
      skid_mis   <= 1'b0;
    end else if (flush) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      ready_q    <= 1'b1;
    end else begin
      main_valid <= main_valid_d;
      skid_valid <= skid_valid_d;
      ready_q    <= !skid_valid_d;
      if (main_load_skid) begin
        main_data <= skid_data;
        main_tag  <= skid_tag;
        main_mis  <= skid_mis;
      end else if (main_load_new) begin
        main_data <= res_data;
        main_tag  <= in_tag;
        main_mis  <= res_mis;
      end
      if (skid_load_new) begin
        skid_data <= res_data;
        skid_tag  <= in_tag;
        skid_mis  <= res_mis;
      end
    end
  end

  assign in_ready     = ready_q;
  assign out_valid    = main_valid;
  assign out_data     = main_data;
  assign out_tag      = main_tag;
  assign out_misalign = main_mis;

endmodule

// File: tb/tb_load_align_extend.sv
module tb_load_align_extend;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // 32-bit instance
  logic        flush, in_valid, in_ready, in_signed, out_valid, out_ready, out_misalign;
  logic [31:0] in_data, out_data;
  logic [1:0]  in_offset, in_size;
  logic [4:0]  in_tag, out_tag;

  // 64-bit instance
  logic        w_flush, w_in_valid, w_in_ready, w_in_signed, w_out_valid, w_out_ready, w_out_misalign;
  logic [63:0] w_in_data, w_out_data;
  logic [2:0]  w_in_offset;
  logic [1:0]  w_in_size;
  logic [4:0]  w_in_tag, w_out_tag;

  int passed = 0;
  int total  = 0;

  load_align_extend #(.DATA_W(32), .TAG_W(5)) dut32 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_offset(in_offset), .in_size(in_size), .in_signed(in_signed), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_tag(out_tag), .out_misalign(out_misalign)
  );

  load_align_extend #(.DATA_W(64), .TAG_W(5)) dut64 (
    .clk(clk), .rst(rst), .flush(w_flush),
    .in_valid(w_in_valid), .in_ready(w_in_ready), .in_data(w_in_data),
    .in_offset(w_in_offset), .in_size(w_in_size), .in_signed(w_in_signed), .in_tag(w_in_tag),
    .out_valid(w_out_valid), .out_ready(w_out_ready), .out_data(w_out_data),
    .out_tag(w_out_tag), .out_misalign(w_out_misalign)
  );

  // Presents one load for exactly one edge, then deasserts in_valid.
  task automatic load32(input logic [31:0] d, input logic [1:0] off, input logic [1:0] sz,
                        input logic sg, input logic [4:0] tg);
    in_valid = 1'b1; in_data = d; in_offset = off; in_size = sz; in_signed = sg; in_tag = tg;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic load64(input logic [63:0] d, input logic [2:0] off, input logic [1:0] sz,
                        input logic sg, input logic [4:0] tg);
    w_in_valid = 1'b1; w_in_data = d; w_in_offset = off; w_in_size = sz; w_in_signed = sg; w_in_tag = tg;
    @(posedge clk); #1;
    w_in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", out_valid); else passed++;
    total++; if (out_data !== 32'h0) $display("FAIL reset_out_data got %h want 00000000", out_data); else passed++;
    total++; if (out_tag !== 5'd0) $display("FAIL reset_out_tag got %0d want 0", out_tag); else passed++;
    total++; if (out_misalign !== 1'b0) $display("FAIL reset_misalign got %b want 0", out_misalign); else passed++;
    total++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", in_ready); else passed++;
    total++; if (w_out_valid !== 1'b0) $display("FAIL reset64_out_valid got %b want 0", w_out_valid); else passed++;
  endtask

  task automatic test_byte();
    logic [31:0] exp_s [4];
    logic [31:0] exp_u [4];
    exp_s = '{32'h00000001, 32'h0000007F, 32'hFFFFFFFF, 32'hFFFFFF80};
    exp_u = '{32'h00000001, 32'h0000007F, 32'h000000FF, 32'h00000080};
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      load32(32'h80FF7F01, 2'(i), 2'd0, 1'b1, 5'(i));
      total++; if (out_valid !== 1'b1 || out_data !== exp_s[i])
        $display("FAIL byte_signed[%0d] got v=%b %h want v=1 %h", i, out_valid, out_data, exp_s[i]); else passed++;
      total++; if (out_tag !== 5'(i)) $display("FAIL byte_signed_tag[%0d] got %0d want %0d", i, out_tag, i); else passed++;
    end
    for (int i = 0; i < 4; i++) begin
      load32(32'h80FF7F01, 2'(i), 2'd0, 1'b0, 5'(i + 4));
      total++; if (out_valid !== 1'b1 || out_data !== exp_u[i] || out_misalign !== 1'b0)
        $display("FAIL byte_unsigned[%0d] got v=%b %h m=%b want v=1 %h m=0", i, out_valid, out_data, out_misalign, exp_u[i]); else passed++;
    end
  endtask

  task automatic test_half_misalign();
    logic [1:0]  offs [3];
    logic [31:0] exp_d [3];
    logic        exp_m [3];
    offs  = '{2'd0, 2'd2, 2'd1};
    exp_d = '{32'hFFFFABCD, 32'hFFFF8001, 32'h00000000};
    exp_m = '{1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 3; i++) begin
      load32(32'h8001ABCD, offs[i], 2'd1, 1'b1, 5'(10 + i));
      total++; if (out_valid !== 1'b1 || out_data !== exp_d[i] || out_misalign !== exp_m[i])
        $display("FAIL half[%0d] got v=%b %h m=%b want v=1 %h m=%b", i, out_valid, out_data, out_misalign, exp_d[i], exp_m[i]); else passed++;
      total++; if (out_tag !== 5'(10 + i)) $display("FAIL half_tag[%0d] got %0d want %0d", i, out_tag, 10 + i); else passed++;
    end
    load32(32'hDEADBEEF, 2'd2, 2'd2, 1'b1, 5'd13);
    total++; if (out_data !== 32'h0 || out_misalign !== 1'b1)
      $display("FAIL word_misalign got %h m=%b want 00000000 m=1", out_data, out_misalign); else passed++;
    load32(32'hDEADBEEF, 2'd0, 2'd2, 1'b1, 5'd14);
    total++; if (out_data !== 32'hDEADBEEF || out_misalign !== 1'b0)
      $display("FAIL word_pass got %h m=%b want deadbeef m=0", out_data, out_misalign); else passed++;
    load32(32'h12345678, 2'd0, 2'd3, 1'b0, 5'd15);
    total++; if (out_data !== 32'h0 || out_misalign !== 1'b1 || out_tag !== 5'd15)
      $display("FAIL illegal_size got %h m=%b t=%0d want 00000000 m=1 t=15", out_data, out_misalign, out_tag); else passed++;
    @(posedge clk); #1;
    total++; if (out_valid !== 1'b0) $display("FAIL drain_empty got %b want 0", out_valid); else passed++;
  endtask

  task automatic test_back_pressure();
    out_ready = 1'b0;
    in_valid = 1'b1; in_offset = 2'd0; in_size = 2'd0; in_signed = 1'b0;
    in_data = 32'h00000001; in_tag = 5'd1;
    @(posedge clk); #1;
    total++; if (out_valid !== 1'b1 || out_tag !== 5'd1 || in_ready !== 1'b1)
      $display("FAIL bp_first got v=%b t=%0d r=%b want v=1 t=1 r=1", out_valid, out_tag, in_ready); else passed++;
    in_data = 32'h00000002; in_tag = 5'd2;
    @(posedge clk); #1;
    total++; if (in_ready !== 1'b0 || out_tag !== 5'd1)
      $display("FAIL bp_skid_full got r=%b t=%0d want r=0 t=1", in_ready, out_tag); else passed++;
    in_data = 32'h00000003; in_tag = 5'd3;
    @(posedge clk); #1;
    total++; if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_tag !== 5'd1 || out_data !== 32'h1)
      $display("FAIL bp_hold got r=%b v=%b t=%0d d=%h want r=0 v=1 t=1 d=00000001", in_ready, out_valid, out_tag, out_data); else passed++;
    out_ready = 1'b1;
    @(posedge clk); #1;
    total++; if (out_valid !== 1'b1 || out_tag !== 5'd2 || out_data !== 32'h2 || in_ready !== 1'b1)
      $display("FAIL bp_second got v=%b t=%0d d=%h r=%b want v=1 t=2 d=00000002 r=1", out_valid, out_tag, out_data, in_ready); else passed++;
    @(posedge clk); #1;
    in_valid = 1'b0;
    total++; if (out_valid !== 1'b1 || out_tag !== 5'd3 || out_data !== 32'h3)
      $display("FAIL bp_third got v=%b t=%0d d=%h want v=1 t=3 d=00000003", out_valid, out_tag, out_data); else passed++;
    @(posedge clk); #1;
    total++; if (out_valid !== 1'b0) $display("FAIL bp_no_dup got v=%b t=%0d want v=0", out_valid, out_tag); else passed++;
  endtask

  task automatic test_flush();
    int seen;
    out_ready = 1'b0;
    in_valid = 1'b1; in_offset = 2'd0; in_size = 2'd0; in_signed = 1'b0;
    in_data = 32'h00000004; in_tag = 5'd4;
    @(posedge clk); #1;
    in_data = 32'h00000005; in_tag = 5'd5;
    @(posedge clk); #1;
    total++; if (out_valid !== 1'b1 || in_ready !== 1'b0)
      $display("FAIL flush_pre got v=%b r=%b want v=1 r=0", out_valid, in_ready); else passed++;
    in_data = 32'h00000006; in_tag = 5'd6; flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    total++; if (out_valid !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL flush_clear got v=%b r=%b want v=0 r=1", out_valid, in_ready); else passed++;
    // The flush cycle can also present an input once in_ready is back; it must not survive.
    in_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    seen = 0;
    for (int i = 0; i < 3; i++) begin
      if (out_valid) seen++;
      @(posedge clk); #1;
    end
    total++; if (seen != 0) $display("FAIL flush_discard got %0d results want 0", seen); else passed++;
    load32(32'h000000C7, 2'd0, 2'd0, 1'b0, 5'd7);
    total++; if (out_valid !== 1'b1 || out_tag !== 5'd7 || out_data !== 32'h000000C7)
      $display("FAIL flush_after got v=%b t=%0d d=%h want v=1 t=7 d=000000c7", out_valid, out_tag, out_data); else passed++;
    @(posedge clk); #1;
  endtask

  task automatic test_dword64();
    w_out_ready = 1'b1;
    load64(64'h87654321_00000000, 3'd4, 2'd2, 1'b1, 5'd20);
    total++; if (w_out_valid !== 1'b1 || w_out_data !== 64'hFFFFFFFF87654321 || w_out_misalign !== 1'b0)
      $display("FAIL w64_word_signed got v=%b %h m=%b want v=1 ffffffff87654321 m=0", w_out_valid, w_out_data, w_out_misalign); else passed++;
    load64(64'h87654321_00000000, 3'd4, 2'd2, 1'b0, 5'd21);
    total++; if (w_out_data !== 64'h0000000087654321)
      $display("FAIL w64_word_unsigned got %h want 0000000087654321", w_out_data); else passed++;
    load64(64'h87654321_00000000, 3'd0, 2'd3, 1'b1, 5'd22);
    total++; if (w_out_data !== 64'h87654321_00000000 || w_out_misalign !== 1'b0 || w_out_tag !== 5'd22)
      $display("FAIL w64_dword_pass got %h m=%b t=%0d want 8765432100000000 m=0 t=22", w_out_data, w_out_misalign, w_out_tag); else passed++;
    load64(64'h87654321_00000000, 3'd4, 2'd3, 1'b1, 5'd23);
    total++; if (w_out_data !== 64'h0 || w_out_misalign !== 1'b1 || w_out_tag !== 5'd23)
      $display("FAIL w64_dword_misalign got %h m=%b t=%0d want 0 m=1 t=23", w_out_data, w_out_misalign, w_out_tag); else passed++;
    load64(64'h00000000_0000C000, 3'd1, 2'd0, 1'b1, 5'd24);
    total++; if (w_out_data !== 64'hFFFFFFFFFFFFFFC0)
      $display("FAIL w64_byte_signed got %h want ffffffffffffffc0", w_out_data); else passed++;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    in_valid = 1'b1; in_offset = 2'd0; in_size = 2'd0; in_signed = 1'b0;
    in_data = 32'h000000AA; in_tag = 5'd8;
    @(posedge clk); #1;
    in_tag = 5'd9;
    @(posedge clk); #1;
    total++; if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_data !== 32'hAA)
      $display("FAIL rstmid_pre got v=%b r=%b d=%h want v=1 r=0 d=000000aa", out_valid, in_ready, out_data); else passed++;
    in_valid = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    total++; if (out_valid !== 1'b0 || out_data !== 32'h0 || out_tag !== 5'd0 || out_misalign !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL rstmid_clear got v=%b d=%h t=%0d m=%b r=%b want all 0 r=1", out_valid, out_data, out_tag, out_misalign, in_ready); else passed++;
    out_ready = 1'b1;
    load32(32'h00001234, 2'd0, 2'd1, 1'b0, 5'd17);
    total++; if (out_valid !== 1'b1 || out_data !== 32'h00001234 || out_tag !== 5'd17)
      $display("FAIL rstmid_after got v=%b d=%h t=%0d want v=1 d=00001234 t=17", out_valid, out_data, out_tag); else passed++;
    @(posedge clk); #1;
    total++; if (out_valid !== 1'b0) $display("FAIL rstmid_drain got %b want 0", out_valid); else passed++;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_data = '0; in_offset = '0; in_size = '0; in_signed = 1'b0; in_tag = '0;
    w_flush = 1'b0; w_in_valid = 1'b0; w_out_ready = 1'b1;
    w_in_data = '0; w_in_offset = '0; w_in_size = '0; w_in_signed = 1'b0; w_in_tag = '0;
    test_reset();
    test_byte();
    test_half_misalign();
    test_back_pressure();
    test_flush();
    test_dword64();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got no finish want finish before 100000");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/load_align_extend.md
Name: load_align_extend

Overview:
- Pipelined load-data alignment and extension stage, placed between the data-memory read port and the register-file write-back mux.
- Selects a byte, halfword or word lane from a DATA_W-wide memory word using the low address bits, then zero- or sign-extends it to DATA_W.
- Flags misaligned accesses.
- Uses a valid/ready handshake with a 2-entry skid buffer, so in_ready is a registered signal and back-pressure never creates a combinational path.

Parameters:
- DATA_W, 32, datapath width; must be 32 or 64.
- TAG_W, 5, width of the side-band tag (destination register number) carried with each load.
- OFF_W, derived as log2(DATA_W/8); not user-settable; width of in_offset.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- flush  input  1  synchronous pipeline flush; discards all held entries
- in_valid  input  1  input transfer request
- in_ready  output  1  stage can accept; registered
- in_data  input  DATA_W  raw aligned memory word
- in_offset  input  OFF_W  low byte-address bits of the load
- in_size  input  2  access size: 0 byte, 1 half, 2 word, 3 dword
- in_signed  input  1  1 sign-extend, 0 zero-extend
- in_tag  input  TAG_W  side-band tag, passed through unchanged
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts the result
- out_data  output  DATA_W  extended result
- out_tag  output  TAG_W  tag of the result
- out_misalign  output  1  address-error flag for this result

Behaviour:
- Transfers: an input transfer occurs when in_valid && in_ready on a clock edge; an output transfer occurs when out_valid && out_ready.
- Reset: out_valid=0, out_data=0, out_tag=0, out_misalign=0, skid entry empty, in_ready=1 in the cycle after rst is sampled high.
- Storage: a main output register plus one skid register, giving 2 entries.
- in_ready (registered): next in_ready = skid entry empty after this edge's updates.
- Latency and throughput: accepted data appears on out_* on the next edge when the main register is free or draining; sustained throughput is 1 result per cycle with out_ready=1.
- Buffer update per edge, with flush and rst taking precedence over everything below:
  - Accept while (main empty || out transfer): write the result to the main register, or, if the skid is occupied, move skid to main and write the new result to skid.
  - Accept while main is full and no out transfer: write the result to skid; in_ready drops to 0 next cycle.
  - No accept with an out transfer: skid moves to main, or out_valid=0 if the skid is empty.
  - Ordering is strictly FIFO; no result may be lost or duplicated.
- Lane select: the selected lane is in_data shifted right by 8*in_offset, with offset bits below the access size forced to 0. Little-endian: offset 0 is in_data[7:0].
- Extension:
  - Byte: bit 7 of the lane is replicated when in_signed=1; zeros otherwise.
  - Half: bit 15 is replicated.
  - Word: bit 31 is replicated when DATA_W=64; when DATA_W=32 the word passes through unchanged.
  - Dword: passes through unchanged.
- Misalignment:
  - Half with offset[0]=1, word with offset[1:0]≠0, or dword with offset≠0 gives out_misalign=1 and out_data=0; the tag still passes through and the entry obeys the normal handshake.
- Illegal size: in_size=3 with DATA_W=32 is illegal. The stage returns out_misalign=1 and out_data=0.
- Flush: on an edge with flush=1, both entries clear, out_valid=0 and in_ready=1 next cycle. An input presented on the flush cycle is discarded and counts as not accepted. An out transfer on the flush cycle still completes for the consumer.
- Reset mid-operation: identical to flush, and additionally clears the data and tag registers to 0.
- out_* holds stable while out_valid && !out_ready.

Test Plan:
- Signed and unsigned byte, DATA_W=32: in_data=32'h80FF7F01, size=0, signed=1, offsets 0,1,2,3 → out_data 32'h00000001, 32'h0000007F, 32'hFFFFFFFF, 32'hFFFFFF80. Repeat with signed=0 → 32'h00000001, 32'h0000007F, 32'h000000FF, 32'h00000080. Each result appears 1 cycle after its accept.
- Halfword and misalignment: in_data=32'h8001ABCD, size=1, signed=1: offset=0 → 32'hFFFFABCD; offset=2 → 32'hFFFF8001; offset=1 → out_data=0, out_misalign=1, tag preserved.
- Back-pressure: out_ready=0, three back-to-back valid inputs with tags 1,2,3 → tags 1 and 2 are accepted and in_ready=0 from the next cycle on. Raise out_ready → outputs emerge in order 1,2,3 with no loss or duplication.
- Flush: two entries held, flush=1 with in_valid=1 on the same edge → out_valid=0 and in_ready=1 next cycle; the flush-cycle input never appears on the output.
- 64-bit build, DATA_W=64: size=2, offset=4, signed=1, in_data=64'h87654321_00000000 → 64'hFFFFFFFF87654321. size=3, offset=0 → passthrough. size=3, offset=4 → out_misalign=1.
- Reset mid-stream: rst=1 while out_valid=1 and the skid is full → next cycle all outputs are 0 and in_ready=1; a following load completes normally.
